// File: rtl/bcd_display_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bcd_display_pkg
// Shared types and constants for the multiplexed BCD display controller.
//   state_t         : conversion sequencer states (IDLE, LOAD, SHIFT, COMMIT)
//   BCD_W           : width of one BCD digit
//   BLANK_CODE      : digit code the downstream decoder renders as all-off
//   maxDisplayValue : largest value representable on a given number of digits
// -----------------------------------------------------------------------------
package bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

  // 10^numDigits - 1, evaluated at elaboration time to size the overflow check.
  function automatic int unsigned maxDisplayValue(input int unsigned numDigits);
    int unsigned v;
    v = 1;
    for (int unsigned i = 0; i < numDigits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/bcd_display_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// bcd_display_scan_ctrl_if
// Bundles the load handshake and the scan outputs of the display controller.
//   start     : single-cycle load request from the value source
//   bin_in    : unsigned value sampled when start is accepted
//   busy      : conversion in progress
//   done      : one-cycle pulse when new digits are committed
//   overflow  : value did not fit on the display (sticky until next load)
//   digit_sel : one-hot active-high digit enable
//   bcd_digit : code for the shared decoder, belongs to the selected digit
// Modports: master = value source / display side, slave = controller.
// -----------------------------------------------------------------------------
interface bcd_display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
);

  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic [3:0]            bcd_digit;

  modport master (
    output start, bin_in,
    input  busy, done, overflow, digit_sel, bcd_digit
  );

  modport slave (
    input  start, bin_in,
    output busy, done, overflow, digit_sel, bcd_digit
  );

endinterface

// File: rtl/bcd_scan_timer.sv
// -----------------------------------------------------------------------------
// bcd_scan_timer
// Free-running digit scan timebase. A prescaler dwells SCAN_DIV clocks on each
// digit, then the scan index advances and wraps after the last digit.
// Ports:
//   clk         : system clock, rising edge
//   reset       : synchronous active-high reset
//   o_nextIndex : index the scan will hold after the coming edge
//   o_digitSel  : registered one-hot digit select
// -----------------------------------------------------------------------------
module bcd_scan_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int PRE_W     = $clog2(SCAN_DIV)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [IDX_W-1:0]      o_nextIndex,
  output logic [NUM_DIGITS-1:0] o_digitSel
);

  logic [PRE_W-1:0]      r_prescaler;
  logic [IDX_W-1:0]      r_index;
  logic [NUM_DIGITS-1:0] r_digitSel;
  logic                  w_wrap;
  logic [IDX_W-1:0]      w_nextIndex;

  // The next index is exported so the owner of the digit registers can load
  // the matching code on the same edge the select moves, keeping the select
  // and the code in lockstep.
  always_comb begin
    w_wrap      = (r_prescaler == PRE_W'(SCAN_DIV - 1));
    w_nextIndex = r_index;
    if (w_wrap) begin
      if (r_index == IDX_W'(NUM_DIGITS - 1)) begin
        w_nextIndex = '0;
      end else begin
        w_nextIndex = r_index + 1'b1;
      end
    end
  end

  // Prescaler, index and one-hot select all advance together; the select is
  // derived from the next index so it never lags the index by a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prescaler <= '0;
      r_index     <= '0;
      r_digitSel  <= NUM_DIGITS'(1);
    end else begin
      r_prescaler <= w_wrap ? '0 : r_prescaler + 1'b1;
      r_index     <= w_nextIndex;
      r_digitSel  <= NUM_DIGITS'(1) << w_nextIndex;
    end
  end

  assign o_nextIndex = w_nextIndex;
  assign o_digitSel  = r_digitSel;

endmodule

// File: rtl/bcd_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_display_scan_ctrl
// Converts a binary value to BCD with a sequential double-dabble engine,
// commits the digits, and time-multiplexes them onto one shared decoder.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : bcd_display_scan_ctrl_if.slave (start/bin_in in; busy, done,
//           overflow, digit_sel, bcd_digit out)
// Build option:
//   BCD_SCAN_LEADING_BLANK_EN : when defined, leading zero digits above the
//                               highest nonzero digit are committed as blanks.
// -----------------------------------------------------------------------------
module bcd_display_scan_ctrl
  import bcd_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  bcd_display_scan_ctrl_if.slave  bus
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam int ACC_W   = BCD_W * NUM_DIGITS;
  localparam logic [63:0] MAX_VAL = 64'(maxDisplayValue(NUM_DIGITS));

  state_t               r_state;
  state_t               w_nextState;
  logic                 w_busy;
  logic [BIN_W-1:0]     r_bin;
  logic [ACC_W-1:0]     r_bcd;
  logic [ACC_W-1:0]     w_bcdAdj;
  logic [CNT_W-1:0]     r_shiftCnt;
  logic                 r_overflow;
  logic                 r_done;
  logic [BCD_W-1:0]     r_digitReg  [NUM_DIGITS];
  logic [BCD_W-1:0]     w_commitVal [NUM_DIGITS];
  logic [BCD_W-1:0]     r_bcdDigit;
  logic [IDX_W-1:0]     w_nextIndex;
  logic [NUM_DIGITS-1:0] w_digitSel;
`ifdef BCD_SCAN_LEADING_BLANK_EN
  logic                 w_seenNonZero;
`endif

  // Scan timebase runs regardless of what the converter is doing.
  bcd_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .o_nextIndex (w_nextIndex),
    .o_digitSel  (w_digitSel)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A start seen outside IDLE is simply dropped. SHIFT
  // lasts BIN_W cycles, one per input bit.
  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_nextState = LOAD;
        end
      end
      LOAD: begin
        w_busy      = 1'b1;
        w_nextState = SHIFT;
      end
      SHIFT: begin
        w_busy = 1'b1;
        if (r_shiftCnt == CNT_W'(BIN_W - 1)) begin
          w_nextState = COMMIT;
        end
      end
      COMMIT: begin
        w_busy      = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Double-dabble correction: any nibble of 5 or more gets 3 added so the
  // following left shift carries correctly into the next decimal digit.
  always_comb begin
    w_bcdAdj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[i*BCD_W +: BCD_W] >= BCD_W'(5)) begin
        w_bcdAdj[i*BCD_W +: BCD_W] = r_bcd[i*BCD_W +: BCD_W] + BCD_W'(3);
      end
    end
  end

  // Values to commit. Overflow overrides everything with blanks; otherwise
  // the optional leading-zero blanking walks down from the top digit and
  // stops at the first nonzero one. Digit 0 is never blanked.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_commitVal[i] = r_bcd[i*BCD_W +: BCD_W];
    end
`ifdef BCD_SCAN_LEADING_BLANK_EN
    w_seenNonZero = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (!w_seenNonZero && (w_commitVal[i] == '0)) begin
        w_commitVal[i] = BLANK_CODE;
      end else begin
        w_seenNonZero = 1'b1;
      end
    end
`endif
    if (r_overflow) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        w_commitVal[i] = BLANK_CODE;
      end
    end
  end

  // Conversion datapath and digit registers. The decoder code register is
  // loaded from the digit the scan is about to select, so it changes on the
  // same edge as digit_sel and a fresh commit shows up one edge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_shiftCnt <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      r_bcdDigit <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_digitReg[i] <= '0;
      end
    end else begin
      r_done     <= 1'b0;
      r_bcdDigit <= r_digitReg[w_nextIndex];
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_bin <= bus.bin_in;
          end
        end
        LOAD: begin
          r_bcd      <= '0;
          r_shiftCnt <= '0;
          r_overflow <= (64'(r_bin) > MAX_VAL);
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_bcdAdj[ACC_W-2:0], r_bin, 1'b0};
          r_shiftCnt     <= r_shiftCnt + 1'b1;
        end
        COMMIT: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            r_digitReg[i] <= w_commitVal[i];
          end
          r_done <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.overflow  = r_overflow;
  assign bus.digit_sel = w_digitSel;
  assign bus.bcd_digit = r_bcdDigit;

endmodule

// File: doc/bcd_display_scan_ctrl.md
Name: bcd_display_scan_ctrl

Overview:
- Sequencer that owns one shared 4-bit BCD-to-7-segment decoder and time-multiplexes it across NUM_DIGITS display digits.
- Accepts a binary value on a start strobe and converts it to BCD with a sequential double-dabble engine. Commits the result to digit registers.
- Continuously scans the digits: one-hot digit select, plus the 4-bit code fed to the decoder.
- Sits between the value source (counter or FSM) and the decoder/display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- BIN_W, 14, binary input width. Must satisfy 2^BIN_W ≥ 10^NUM_DIGITS is not required; overflow is detected.
- SCAN_DIV, 50000, clk cycles per digit dwell (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  load request, single-cycle strobe.
- bin_in  in  BIN_W  unsigned value, sampled when start is accepted.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when new digits are committed.
- overflow  out  1  sticky until next accepted start; bin_in > 10^NUM_DIGITS−1.
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable.
- bcd_digit  out  4  code to the shared decoder for the selected digit.

Behaviour:
- Interface (already decided): one clock, clk. Reset is synchronous and active-high, on the port reset.
- Reset values: busy=0, done=0, overflow=0, all digit regs=4'h0, scan index=0, digit_sel=1 (digit 0), bcd_digit=4'h0, prescaler=0.
- States: IDLE, LOAD, SHIFT, COMMIT.
- IDLE → LOAD: on start=1; bin_in is captured at this edge.
- LOAD (1 cycle):
  - Clear the BCD accumulator (4*NUM_DIGITS bits).
  - Compute overflow = (captured > 10^NUM_DIGITS−1).
  - Reset the shift counter.
- SHIFT (exactly BIN_W cycles): each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,bin} left by 1.
- COMMIT (1 cycle):
  - Write the digit regs: BCD nibbles, or all 4'hF if overflow.
  - Pulse done=1. Return to IDLE.
- Latency: start sampled at edge k → busy=1 from k+1 through the COMMIT cycle. Digit regs and done update at edge k+BIN_W+2. busy=0 again in the cycle after done.
- start while not IDLE: ignored. No queueing, no error flag.
- overflow: cleared in LOAD of the next conversion. Set/held from LOAD until then.
- Scan path, independent of the FSM, never stalls:
  - prescaler counts 0..SCAN_DIV−1.
  - On the wrap edge, scan index increments, wrapping NUM_DIGITS−1 → 0.
  - digit_sel=1<<index; bcd_digit=digit_reg[index]. Both are registered and change on the same edge.
- Digit 0 is the least significant.
- 4'hF is the blank code; the decoder outputs all-off for it.
- Commit during scan: the new digit value appears on bcd_digit at the next edge when that digit is selected. No tearing of digit_sel vs bcd_digit.
- Reset mid-conversion: FSM → IDLE, digit regs cleared to 0, no done pulse.

Optional Feature:
- Macro: BCD_SCAN_LEADING_BLANK_EN.
- Defined: at COMMIT, every most-significant zero digit above the highest nonzero digit is written as 4'hF. Digit 0 is never blanked; value 0 displays "0". Does not apply on overflow, which is all 4'hF regardless.
- Undefined: leading zeros are shown as 4'h0.

Decomposition:
- Package bcd_display_pkg:
  - state enum (IDLE, LOAD, SHIFT, COMMIT)
  - BCD_W=4
  - BLANK_CODE=4'hF
  - function for the 10^N limit
- One sub-module: bcd_scan_timer, holding the prescaler, scan index and one-hot select. The top holds the FSM, double-dabble and digit regs.

Test Plan:
- Conversion, 1234: SCAN_DIV=4, BIN_W=14, start with bin_in=1234 → done exactly 16 cycles after the start edge; digits[3:0]=1,2,3,4; overflow=0; busy high for 16 cycles.
- Upper limit: bin_in=9999 → digits 9,9,9,9, overflow=0. bin_in=10000 → digits F,F,F,F, overflow=1. Then bin_in=7 → overflow clears in LOAD; digits 0,0,0,7, or F,F,F,7 with BCD_SCAN_LEADING_BLANK_EN.
- Start ignored while busy: start=1 at k (bin_in=5555), start=1 again at k+3 (bin_in=1111) → single done; digits 5,5,5,5.
- Scan wrap, SCAN_DIV=4: digit_sel sequence 0001→0010→0100→1000→0001, each held 4 cycles. bcd_digit matches digit_reg[index] on every cycle.
- Reset mid-conversion: assert reset at k+5 of a conversion → next cycle busy=0, digits 0, digit_sel=0001. No done pulse through k+20.
- Leading blank with macro defined: bin_in=42 → F,F,4,2. bin_in=0 → F,F,F,0.
